// File: rtl/clk_div_multi.sv
// Multi-channel clock divider and tick generator.
// Double-buffered period/high-time config applied only at period boundaries.
module clk_div_multi #(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 27,
  parameter int CH_W    = 2,
  parameter int DEF_DIV = 100000000,
  parameter int DEF_HI  = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_all,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_hi,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pend
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DIV0 = CNT_W'(DEF_DIV);
  localparam cnt_t HI0  = CNT_W'(DEF_HI);
  localparam cnt_t ONE  = CNT_W'(1);
  localparam cnt_t TWO  = CNT_W'(2);

  cnt_t cnt_q   [NUM_CH];
  cnt_t cnt_d   [NUM_CH];
  cnt_t div_a_q [NUM_CH];
  cnt_t div_a_d [NUM_CH];
  cnt_t hi_a_q  [NUM_CH];
  cnt_t hi_a_d  [NUM_CH];
  cnt_t div_s_q [NUM_CH];
  cnt_t div_s_d [NUM_CH];
  cnt_t hi_s_q  [NUM_CH];
  cnt_t hi_s_d  [NUM_CH];
  cnt_t lim     [NUM_CH];

  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wr, take, start;

  // Last count of the period; div values 0 and 1 behave as 2.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      lim[i] = (div_a_q[i] < TWO) ? ONE
                                  : div_a_q[i] - ONE;
      wr[i]  = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  always_comb begin
    run_d     = run_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;
    take      = '0;
    start     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      div_a_d[i] = div_a_q[i];
      hi_a_d[i]  = hi_a_q[i];
      div_s_d[i] = div_s_q[i];
      hi_s_d[i]  = hi_s_q[i];

      if (!run_q[i]) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        tick_d[i]    = 1'b0;
        take[i]      = pend_q[i];
        if (en[i]) begin
          run_d[i]  = 1'b1;
          tick_d[i] = 1'b1;
          start[i]  = 1'b1;
        end
      end else if (!en[i]) begin
        run_d[i]     = 1'b0;
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        tick_d[i]    = 1'b0;
      end else if (sync_all || cnt_q[i] == lim[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        take[i]   = pend_q[i];
        start[i]  = 1'b1;
      end else begin
        cnt_d[i]     = cnt_q[i] + ONE;
        tick_d[i]    = 1'b0;
        clk_out_d[i] = (cnt_q[i] + ONE) < hi_a_q[i];
      end

      if (take[i]) begin
        div_a_d[i] = div_s_q[i];
        hi_a_d[i]  = hi_s_q[i];
        pend_d[i]  = 1'b0;
      end

      // The tick cycle already uses the freshly applied high time.
      if (start[i]) begin
        clk_out_d[i] = (hi_a_d[i] != '0);
      end

      if (wr[i]) begin
        div_s_d[i] = cfg_div;
        hi_s_d[i]  = cfg_hi;
        pend_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q     <= '0;
      pend_q    <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]   <= '0;
        div_a_q[i] <= DIV0;
        hi_a_q[i]  <= HI0;
        div_s_q[i] <= DIV0;
        hi_s_q[i]  <= HI0;
      end
    end else begin
      run_q     <= run_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        div_a_q[i] <= div_a_d[i];
        hi_a_q[i]  <= hi_a_d[i];
        div_s_q[i] <= div_s_d[i];
        hi_s_q[i]  <= hi_s_d[i];
      end
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign cfg_pend = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized scoreboard bench for clk_div_multi.
// Reference model tracks each channel by period start time.
module tb_clk_div_multi;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DD  = 10;
  localparam int DH  = 5;

  logic           clk = 0;
  logic           rst = 0;
  logic [NCH-1:0] en = '0;
  logic           sync_all = 0;
  logic           cfg_we = 0;
  logic [1:0]     cfg_ch = '0;
  logic [CW-1:0]  cfg_div = '0;
  logic [CW-1:0]  cfg_hi = '0;
  logic [NCH-1:0] clk_out, tick, cfg_pend;

  clk_div_multi #(
    .NUM_CH(NCH), .CNT_W(CW), .CH_W(2),
    .DEF_DIV(DD), .DEF_HI(DH)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .sync_all(sync_all), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_hi(cfg_hi), .clk_out(clk_out),
    .tick(tick), .cfg_pend(cfg_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
    int             n;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Model: period starts at edge m_start; phase = edges since then.
  int n = 0;
  int m_run[NCH], m_start[NCH];
  int m_da[NCH], m_ha[NCH], m_ds[NCH], m_hs[NCH], m_pend[NCH];

  function automatic int per(int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int phase(int i);
    return n - m_start[i];
  endfunction

  task automatic push_exp();
    exp_t e;
    e.n = n;
    for (int i = 0; i < NCH; i++) begin
      e.c[i] = m_run[i] != 0 && phase(i) < m_ha[i];
      e.t[i] = m_run[i] != 0 && phase(i) == 0;
      e.p[i] = m_pend[i] != 0;
    end
    q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_start[i] = 0; m_pend[i] = 0;
      m_da[i] = DD; m_ha[i] = DH;
      m_ds[i] = DD; m_hs[i] = DH;
    end
  endtask

  task automatic model_step();
    bit tk, st;
    n++;
    for (int i = 0; i < NCH; i++) begin
      tk = 0; st = 0;
      if (m_run[i] == 0) begin
        tk = m_pend[i] != 0;
        if (en[i]) begin m_run[i] = 1; st = 1; end
      end else if (!en[i]) begin
        m_run[i] = 0;
      end else if (sync_all ||
                   phase(i) == per(m_da[i])) begin
        st = 1; tk = m_pend[i] != 0;
      end
      if (tk) begin
        m_da[i] = m_ds[i]; m_ha[i] = m_hs[i];
        m_pend[i] = 0;
      end
      if (st) m_start[i] = n;
      if (cfg_we && int'(cfg_ch) == i) begin
        m_ds[i] = int'(cfg_div);
        m_hs[i] = int'(cfg_hi);
        m_pend[i] = 1;
      end
    end
  endtask

  task automatic step(int k);
    for (int j = 0; j < k; j++) begin
      @(posedge clk);
      model_step();
      push_exp();
      @(negedge clk);
      cfg_we = 0;
      sync_all = 0;
    end
  endtask

  task automatic wr(int ch, int d, int h);
    cfg_we = 1;
    cfg_ch = 2'(ch);
    cfg_div = CW'(d);
    cfg_hi = CW'(h);
  endtask

  task automatic do_reset();
    rst = 1;
    en = '0;
    model_reset();
    push_exp();
    #2;
    rst = 0;
  endtask

  task automatic chk(string nm, int ch, int cyc,
                     logic a, logic b);
    checks++;
    if (a !== b) begin
      failures++;
      $display("FAIL %s ch%0d edge%0d got=%b exp=%b",
               nm, ch, cyc, a, b);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int i = 0; i < NCH; i++) begin
          chk("clk_out", i, e.n, clk_out[i], e.c[i]);
          chk("tick", i, e.n, tick[i], e.t[i]);
          chk("cfg_pend", i, e.n, cfg_pend[i], e.p[i]);
        end
      end
    end
  end

  initial begin : driver
    int g;
    model_reset();
    @(negedge clk);
    do_reset();
    step(2);

    en = 3'b001;
    step(25);

    en = 3'b011;
    step(3);
    wr(1, 4, 1);
    step(24);

    en = 3'b111;
    step(2);
    wr(2, 1, 1);
    step(12);
    wr(2, 5, 0);
    step(14);
    wr(2, 10, 12);
    step(25);
    wr(3, 3, 1);
    step(14);

    g = 0;
    while (phase(0) != 7 && g < 50) begin
      step(1); g++;
    end
    sync_all = 1;
    step(30);

    wr(0, 6, 3);
    step(1);
    g = 0;
    while (phase(0) != per(m_da[0]) - 1 && g < 50) begin
      step(1); g++;
    end
    wr(0, 8, 2);
    step(30);

    for (int j = 0; j < 400; j++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 24) == 0) en[i] = ~en[i];
      if ($urandom_range(0, 5) == 0)
        wr($urandom_range(0, 3), $urandom_range(0, 20),
           $urandom_range(0, 22));
      if ($urandom_range(0, 39) == 0) sync_all = 1;
      step(1);
    end

    en = 3'b111;
    wr(1, 7, 3);
    step(9);
    do_reset();
    step(2);
    en = 3'b111;
    step(25);

    step(2);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider and tick generator; successor to the fixed 1 Hz and 10 kHz dividers. It produces NUM_CH independent divided clocks from the single system clock, each with a runtime-programmable period and high time, plus a one-cycle tick strobe per period. New settings are double-buffered and take effect only at a period boundary, so the outputs never glitch. A global sync input phase-aligns all channels. It sits between the board clock and the time-keeping, display-multiplex and debounce logic.

## Interface
- NUM_CH, 3: number of channels
- CNT_W, 27: counter and config field width
- CH_W, 2: width of cfg_ch; must be at least clog2(NUM_CH), minimum 1
- DEF_DIV, 100000000: reset period of every channel, in clk cycles
- DEF_HI, 50000000: reset high time of every channel, in clk cycles
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous reset, active-high
- en  in  NUM_CH  per-channel run enable
- sync_all  in  1  restart all running channels at count 0
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  CH_W  target channel of the write
- cfg_div  in  CNT_W  new period
- cfg_hi  in  CNT_W  new high time
- clk_out  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-cycle strobe at the start of each period, registered
- cfg_pend  out  NUM_CH  shadow written but not yet applied

## Operation
- Per-channel state:
  - cnt (CNT_W)
  - active div_a and hi_a
  - shadow div_s and hi_s
  - pend
  - run
- Reset: cnt=0, div_a=div_s=DEF_DIV, hi_a=hi_s=DEF_HI, run=0, pend=0. Outputs after reset: clk_out=0, tick=0, cfg_pend=0.
- Effective period P = max(div_a, 2). Values 0 and 1 are clamped to 2.
- IDLE (run=0):
  - cnt held at 0, clk_out=0, tick=0.
  - A pending shadow is applied at the next edge.
  - When en[i] is sampled high: run<=1, cnt<=0, tick<=1, pending shadow applied. clk_out is computed from the applied hi.
- RUN (run=1):
  - At each edge: if cnt==P-1, then cnt<=0, tick<=1, and the shadow is applied if pend. Otherwise cnt<=cnt+1 and tick<=0.
  - If en[i] is sampled low: run<=0, cnt<=0, clk_out<=0, tick<=0.
- Output invariant in RUN: clk_out==(cnt<hi_a) and tick==(cnt==0), both evaluated against register values.
  - hi_a==0 gives a constant-low clk_out.
  - hi_a>=P gives a constant-high clk_out.
  - tick still pulses once per period in both cases.
- sync_all, sampled high: every running channel takes the boundary path (cnt<=0, tick<=1, shadow applied if pend). Idle channels are unaffected.
- Priority per channel: rst > en low > IDLE->RUN > sync_all > natural wrap.
- Config write:
  - When cfg_we is high and cfg_ch<NUM_CH: div_s<=cfg_div, hi_s<=cfg_hi, pend<=1.
  - When cfg_ch>=NUM_CH the write is ignored with no state change.
- Write at the same edge as a boundary on that channel: the boundary applies the old shadow value. The new value is stored and pend stays 1 until the next boundary.
- Channels are fully independent apart from sync_all and the shared config bus.

## Timing
- All outputs are registered and change only on the clk posedge, or asynchronously on rst.
- en rise to first tick: 1 edge. tick width: exactly 1 cycle. Tick spacing: exactly P cycles in RUN with no sync_all.
- In RUN, clk_out is high for min(hi_a,P) cycles of each period, starting in the tick cycle.
- Config latency:
  - cfg_pend rises 1 edge after cfg_we.
  - New div/hi take effect at the next boundary edge; the tick cycle of that period already uses the new hi.
  - cfg_pend falls at that same edge.
- Disable latency: clk_out=0 one edge after en is sampled low.
- rst asserted mid-period: all outputs go to 0 immediately, and active config returns to DEF_DIV/DEF_HI.
- The counter never exceeds P-1. A shorter div applied at a boundary cannot strand cnt above the new limit, because cnt is 0 at that point.

## Test plan
Bench parameters: NUM_CH=3, CNT_W=8, DEF_DIV=10, DEF_HI=5.

- Reset, then en=3'b001 -> ch0 tick every 10 cycles; clk_out 5 high / 5 low; first tick 1 edge after en; ch1 and ch2 stay 0.
- Write ch1 div=4, hi=1 mid-period while ch1 runs at defaults -> cfg_pend[1] high until the next ch1 tick; after that, period 4 with 1 cycle high; no runt pulse.
- Edge cases on ch2:
  - div=1 -> period clamps to 2.
  - hi=0 -> clk_out constant 0, tick continues.
  - hi=12 with div=10 -> clk_out constant 1.
  - cfg_ch=3 -> write ignored.
- All channels running, ch0 at cnt=7, assert sync_all -> all ticks coincide on the next cycle, then each channel keeps its own period.
- Write coinciding with a ch0 boundary, with an older value pending -> the old value is applied, the new one is pending, and it is applied at the following boundary.
- rst pulse mid-period with a non-default config active -> outputs go to 0 at once; after release, en gives period 10 / high 5.
